// File: rtl/add_sub_pkg.sv
// Shared types and constants for the add/subtract unit.
// Flag indices address the {N, Z, C, V} nibble on FLAGS.
package add_sub_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HAVE_A = 3'd1,
    HAVE_B = 3'd2,
    BUSY   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_core.sv
// Combinational add/subtract datapath with {N,Z,C,V} flags and optional signed saturation.
// No state; the caller registers y and flags.
module add_sub_core
  import add_sub_pkg::*;
#(
  parameter int   BITS = 32,
  parameter logic SAT  = 1'b0
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            sub,
  output logic [BITS-1:0] y,
  output logic [3:0]      flags
);

  logic [BITS-1:0] b_eff;
  logic [BITS:0]   sum;
  logic            ovf;
  logic [BITS-1:0] res;

  always_comb begin
    b_eff = (sub == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{BITS{1'b0}}, sub};
    // Overflow: effective operand signs agree but the result sign does not.
    ovf   = (a[BITS-1] == b_eff[BITS-1]) && (sum[BITS-1] != a[BITS-1]);
    res   = sum[BITS-1:0];
    if (SAT && ovf) begin
      res = a[BITS-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end
    flags         = 4'b0000;
    flags[FLAG_N] = res[BITS-1];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = sum[BITS];
    flags[FLAG_V] = ovf;
    y             = res;
  end

endmodule

// File: rtl/add_sub_unit.sv
// Two-operand add/subtract stage with IEA/IEB capture, CLKS extra busy cycles and OE release handshake.
// Result registers one edge after the last operand; OE rises CLKS+2 edges after it and holds until enables drop.
module add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int         BITS = 32,
  parameter logic [7:0] CLKS = 8'd0,
  parameter logic       SAT  = 1'b0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            IEA,
  input  logic            IEB,
  input  logic            SUB,
  output logic [BITS-1:0] Y,
  output logic [3:0]      FLAGS,
  output logic            OE
);

  state_t          state, state_n;
  logic [7:0]      cnt;
  logic [BITS-1:0] a_q, b_q;
  logic            sub_q;
  logic            fresh;
  logic            ld_a, ld_b, oe_n;
  logic [BITS-1:0] core_y;
  logic [3:0]      core_flags;

  add_sub_core #(
    .BITS (BITS),
    .SAT  (SAT)
  ) u_core (
    .a     (a_q),
    .b     (b_q),
    .sub   (sub_q),
    .y     (core_y),
    .flags (core_flags)
  );

  always_comb begin
    state_n = state;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    case (state)
      IDLE: begin
        if (IEA && IEB) begin
          ld_a    = 1'b1;
          ld_b    = 1'b1;
          state_n = BUSY;
        end else if (IEA) begin
          ld_a    = 1'b1;
          state_n = HAVE_A;
        end else if (IEB) begin
          ld_b    = 1'b1;
          state_n = HAVE_B;
        end
      end
      HAVE_A: if (IEB) begin
        ld_b    = 1'b1;
        state_n = BUSY;
      end
      HAVE_B: if (IEA) begin
        ld_a    = 1'b1;
        state_n = BUSY;
      end
      BUSY:   if (cnt == 8'd0) state_n = DONE;
      DONE:   if (OE && !IEA && !IEB) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // OE rises the edge after DONE entry and drops on the release edge.
    oe_n = (state == DONE) && !(OE && !IEA && !IEB);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= 8'd0;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      fresh <= 1'b0;
      Y     <= '0;
      FLAGS <= 4'b0000;
      OE    <= 1'b0;
    end else begin
      state <= state_n;
      OE    <= oe_n;
      fresh <= (state != BUSY) && (state_n == BUSY);
      if (ld_a) begin
        a_q   <= A;
        sub_q <= SUB;
      end
      if (ld_b) b_q <= B;
      if (state == IDLE) begin
        cnt <= CLKS;
      end else if (state == BUSY && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (state == BUSY && fresh) begin
        Y     <= core_y;
        FLAGS <= core_flags;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_unit.sv
// Directed bench for add_sub_unit at BITS=8 across four CLKS/SAT variants sharing one operand bus.
module tb_add_sub_unit;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] A, B;
  logic       IEA, IEB, SUB;

  logic [7:0] y0, ys, y3, y5;
  logic [3:0] f0, fs, f3, f5;
  logic       oe0, oes, oe3, oe5;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  add_sub_unit #(.BITS(8), .CLKS(8'd0), .SAT(1'b0)) u_d0 (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .IEA(IEA), .IEB(IEB), .SUB(SUB),
    .Y(y0), .FLAGS(f0), .OE(oe0));
  add_sub_unit #(.BITS(8), .CLKS(8'd0), .SAT(1'b1)) u_ds (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .IEA(IEA), .IEB(IEB), .SUB(SUB),
    .Y(ys), .FLAGS(fs), .OE(oes));
  add_sub_unit #(.BITS(8), .CLKS(8'd3), .SAT(1'b0)) u_d3 (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .IEA(IEA), .IEB(IEB), .SUB(SUB),
    .Y(y3), .FLAGS(f3), .OE(oe3));
  add_sub_unit #(.BITS(8), .CLKS(8'd5), .SAT(1'b0)) u_d5 (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .IEA(IEA), .IEB(IEB), .SUB(SUB),
    .Y(y5), .FLAGS(f5), .OE(oe5));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    IEA = 1'b0;
    IEB = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (y0 !== 8'h00)    begin errors++; $display("FAIL rst_y0 got %h exp %h", y0, 8'h00); end
    checks++; if (f0 !== 4'b0000)  begin errors++; $display("FAIL rst_f0 got %b exp %b", f0, 4'b0000); end
    checks++; if (oe0 !== 1'b0)    begin errors++; $display("FAIL rst_oe0 got %b exp %b", oe0, 1'b0); end
    checks++; if (oe5 !== 1'b0)    begin errors++; $display("FAIL rst_oe5 got %b exp %b", oe5, 1'b0); end
    RST_N = 1'b1;
    tick();
    checks++; if (oe0 !== 1'b0)    begin errors++; $display("FAIL idle_oe0 got %b exp %b", oe0, 1'b0); end
  endtask

  task automatic test_overflow();
    A = 8'h7F; B = 8'h01; SUB = 1'b0; IEA = 1'b1; IEB = 1'b1;
    tick();  // t0
    IEA = 1'b0; IEB = 1'b0;
    checks++; if (oe0 !== 1'b0)    begin errors++; $display("FAIL ovf_oe_t0 got %b exp %b", oe0, 1'b0); end
    tick();  // t0+1
    checks++; if (y0 !== 8'h80)    begin errors++; $display("FAIL ovf_y got %h exp %h", y0, 8'h80); end
    checks++; if (f0 !== 4'b1001)  begin errors++; $display("FAIL ovf_flags got %b exp %b", f0, 4'b1001); end
    checks++; if (oe0 !== 1'b0)    begin errors++; $display("FAIL ovf_oe_t1 got %b exp %b", oe0, 1'b0); end
    tick();  // t0+2
    checks++; if (oe0 !== 1'b1)    begin errors++; $display("FAIL ovf_oe_t2 got %b exp %b", oe0, 1'b1); end
    tick();  // t0+3: release with enables low
    checks++; if (oe0 !== 1'b0)    begin errors++; $display("FAIL ovf_release got %b exp %b", oe0, 1'b0); end
    drain();
  endtask

  task automatic test_saturation();
    A = 8'h7F; B = 8'h01; SUB = 1'b0; IEA = 1'b1; IEB = 1'b1;
    tick();
    IEA = 1'b0; IEB = 1'b0;
    tick();
    checks++; if (ys !== 8'h7F)    begin errors++; $display("FAIL sat_y got %h exp %h", ys, 8'h7F); end
    checks++; if (fs !== 4'b0001)  begin errors++; $display("FAIL sat_flags got %b exp %b", fs, 4'b0001); end
    tick();
    checks++; if (oes !== 1'b1)    begin errors++; $display("FAIL sat_oe got %b exp %b", oes, 1'b1); end
    drain();
  endtask

  task automatic test_split_sub();
    A = 8'h05; SUB = 1'b1; IEA = 1'b1;
    tick();
    IEA = 1'b0; SUB = 1'b0; A = 8'h55;
    tick();
    tick();
    B = 8'h07; IEB = 1'b1;
    tick();  // B edge, three cycles after A edge
    IEB = 1'b0; B = 8'hAA;
    checks++; if (oe0 !== 1'b0)    begin errors++; $display("FAIL split_oe_t0 got %b exp %b", oe0, 1'b0); end
    tick();
    checks++; if (y0 !== 8'hFE)    begin errors++; $display("FAIL split_y got %h exp %h", y0, 8'hFE); end
    checks++; if (f0 !== 4'b1000)  begin errors++; $display("FAIL split_flags got %b exp %b", f0, 4'b1000); end
    tick();
    checks++; if (oe0 !== 1'b1)    begin errors++; $display("FAIL split_oe got %b exp %b", oe0, 1'b1); end
    drain();
  endtask

  task automatic test_wrap();
    A = 8'hFF; B = 8'h01; SUB = 1'b0; IEA = 1'b1; IEB = 1'b1;
    tick();
    IEA = 1'b0; IEB = 1'b0;
    tick();
    checks++; if (y0 !== 8'h00)    begin errors++; $display("FAIL wrap_y got %h exp %h", y0, 8'h00); end
    checks++; if (f0 !== 4'b0110)  begin errors++; $display("FAIL wrap_flags got %b exp %b", f0, 4'b0110); end
    drain();
  endtask

  task automatic test_latency_release();
    A = 8'h10; B = 8'h20; SUB = 1'b0; IEA = 1'b1; IEB = 1'b1;
    tick();  // t0
    IEA = 1'b0; IEB = 1'b0;
    tick();  // t0+1
    checks++; if (y3 !== 8'h30)    begin errors++; $display("FAIL lat_y got %h exp %h", y3, 8'h30); end
    checks++; if (f3 !== 4'b0000)  begin errors++; $display("FAIL lat_flags got %b exp %b", f3, 4'b0000); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (oe3 !== 1'b0)  begin errors++; $display("FAIL lat_oe_low_t%0d got %b exp %b", i, oe3, 1'b0); end
      if (i < 4) tick();
    end
    tick();  // t0+5
    checks++; if (oe3 !== 1'b1)    begin errors++; $display("FAIL lat_oe_rise got %b exp %b", oe3, 1'b1); end
    A = 8'h01; IEA = 1'b1;
    tick();  // t0+6: enable held in DONE
    checks++; if (oe3 !== 1'b1)    begin errors++; $display("FAIL hold_oe got %b exp %b", oe3, 1'b1); end
    checks++; if (y3 !== 8'h30)    begin errors++; $display("FAIL hold_y got %h exp %h", y3, 8'h30); end
    IEA = 1'b0;
    tick();  // t0+7: release
    checks++; if (oe3 !== 1'b0)    begin errors++; $display("FAIL drop_oe got %b exp %b", oe3, 1'b0); end
    A = 8'h02; B = 8'h03; IEA = 1'b1; IEB = 1'b1;
    tick();  // t0+8: next capture
    IEA = 1'b0; IEB = 1'b0;
    tick();
    checks++; if (y3 !== 8'h05)    begin errors++; $display("FAIL next_y got %h exp %h", y3, 8'h05); end
    repeat (3) tick();  // t0+12
    checks++; if (oe3 !== 1'b0)    begin errors++; $display("FAIL next_oe_low got %b exp %b", oe3, 1'b0); end
    tick();  // t0+13
    checks++; if (oe3 !== 1'b1)    begin errors++; $display("FAIL next_oe_rise got %b exp %b", oe3, 1'b1); end
    drain();
  endtask

  task automatic test_reset_mid();
    A = 8'h40; B = 8'h40; SUB = 1'b0; IEA = 1'b1; IEB = 1'b1;
    tick();  // t0
    IEA = 1'b0; IEB = 1'b0;
    tick();  // t0+1
    checks++; if (y5 !== 8'h80)    begin errors++; $display("FAIL pre_rst_y got %h exp %h", y5, 8'h80); end
    checks++; if (f5 !== 4'b1001)  begin errors++; $display("FAIL pre_rst_flags got %b exp %b", f5, 4'b1001); end
    tick();  // t0+2: d5 mid-count, d0 showing OE
    RST_N = 1'b0;
    #2;
    checks++; if (y5 !== 8'h00)    begin errors++; $display("FAIL mid_rst_y got %h exp %h", y5, 8'h00); end
    checks++; if (f5 !== 4'b0000)  begin errors++; $display("FAIL mid_rst_flags got %b exp %b", f5, 4'b0000); end
    checks++; if (oe5 !== 1'b0)    begin errors++; $display("FAIL mid_rst_oe5 got %b exp %b", oe5, 1'b0); end
    checks++; if (oe0 !== 1'b0)    begin errors++; $display("FAIL mid_rst_oe0 got %b exp %b", oe0, 1'b0); end
    #2;
    RST_N = 1'b1;
    tick();
    A = 8'h03; B = 8'h04; IEA = 1'b1; IEB = 1'b1;
    tick();  // t0'
    IEA = 1'b0; IEB = 1'b0;
    tick();
    checks++; if (y5 !== 8'h07)    begin errors++; $display("FAIL post_rst_y got %h exp %h", y5, 8'h07); end
    checks++; if (f5 !== 4'b0000)  begin errors++; $display("FAIL post_rst_flags got %b exp %b", f5, 4'b0000); end
    repeat (5) tick();  // t0'+6
    checks++; if (oe5 !== 1'b0)    begin errors++; $display("FAIL post_rst_oe_low got %b exp %b", oe5, 1'b0); end
    tick();  // t0'+7
    checks++; if (oe5 !== 1'b1)    begin errors++; $display("FAIL post_rst_oe_rise got %b exp %b", oe5, 1'b1); end
    drain();
  endtask

  initial begin
    RST_N = 1'b0;
    A = 8'h00; B = 8'h00; IEA = 1'b0; IEB = 1'b0; SUB = 1'b0;
    test_reset();
    test_overflow();
    test_saturation();
    test_split_sub();
    test_wrap();
    test_latency_release();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
